// File: rtl/fwd_hazard_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : fwd_hazard_ctrl_if
// Pipeline-side bundle for fwd_hazard_ctrl: stage status, results and bypass outputs.
// Optional FWD_HAZARD_PERF_EN adds the performance counter outputs.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fwd_hazard_ctrl_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            id_valid;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [AW-1:0]   id_rd;
    logic            id_wen;
    logic            ex_valid;
    logic            ex_wen;
    logic            ex_is_load;
    logic [AW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            mem_valid;
    logic            mem_wen;
    logic            mem_is_load;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_alu;
    logic [XLEN-1:0] mem_ld_data;
    logic            wb_valid;
    logic            wb_wen;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            mc_issue;
    logic [AW-1:0]   mc_issue_rd;
    logic            mc_done;
    logic [AW-1:0]   mc_done_rd;
    logic [XLEN-1:0] mc_result;
    logic            op1_fwd;
    logic            op2_fwd;
    logic [XLEN-1:0] op1_data;
    logic [XLEN-1:0] op2_data;
    logic            stall_id;
    logic            mc_timeout;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]     perf_ldu_stalls;
    logic [31:0]     perf_mc_stalls;
    logic [31:0]     perf_fwd_count;
`endif

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_wen,
        output ex_valid, ex_wen, ex_is_load, ex_rd, ex_result,
        output mem_valid, mem_wen, mem_is_load, mem_rd, mem_alu, mem_ld_data,
        output wb_valid, wb_wen, wb_rd, wb_data,
        output mc_issue, mc_issue_rd, mc_done, mc_done_rd, mc_result,
`ifdef FWD_HAZARD_PERF_EN
        input  perf_ldu_stalls, perf_mc_stalls, perf_fwd_count,
`endif
        input  op1_fwd, op2_fwd, op1_data, op2_data, stall_id, mc_timeout
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_wen,
        input  ex_valid, ex_wen, ex_is_load, ex_rd, ex_result,
        input  mem_valid, mem_wen, mem_is_load, mem_rd, mem_alu, mem_ld_data,
        input  wb_valid, wb_wen, wb_rd, wb_data,
        input  mc_issue, mc_issue_rd, mc_done, mc_done_rd, mc_result,
`ifdef FWD_HAZARD_PERF_EN
        output perf_ldu_stalls, perf_mc_stalls, perf_fwd_count,
`endif
        output op1_fwd, op2_fwd, op1_data, op2_data, stall_id, mc_timeout
    );
endinterface

`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module : fwd_hazard_ctrl
// Operand forwarding, load-use stall, MC scoreboard and stall watchdog.
// Optional FWD_HAZARD_PERF_EN adds saturating stall/forward counters.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fwd_hazard_ctrl #(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int MC_TIMEOUT = 64
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    fwd_hazard_ctrl_if.slave bus
);
    localparam int c_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int c_CW = $clog2(MC_TIMEOUT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(MC_TIMEOUT);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_REGS-1:0] r_sb;
    logic [NUM_REGS-1:0] w_sb_next;
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     w_cnt_next;
    logic                r_timeout;

    logic [c_AW-1:0]     w_rs   [2];
    logic [1:0]          w_used;
    logic [1:0]          w_fwd;
    logic [XLEN-1:0]     w_data [2];
    logic [1:0]          w_ldu;
    logic [1:0]          w_raw;
    logic                w_waw;
    logic                w_sb_stall;
    logic                w_ldu_stall;
    logic                w_stall;

    always_comb begin
        w_rs[0]   = bus.id_rs1;
        w_rs[1]   = bus.id_rs2;
        w_used[0] = bus.id_rs1_used;
        w_used[1] = bus.id_rs2_used;
    end

    // Per-operand match; priority MC completion > EX > MEM > WB, x0 excluded.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_fwd[i]  = 1'b0;
            w_data[i] = '0;
            w_ldu[i]  = 1'b0;
            w_raw[i]  = 1'b0;
            if (w_used[i] && (w_rs[i] != '0)) begin
                if (bus.mc_done && (bus.mc_done_rd == w_rs[i])) begin
                    w_fwd[i]  = 1'b1;
                    w_data[i] = bus.mc_result;
                end else begin
                    w_raw[i] = r_sb[w_rs[i]];
                    if (bus.ex_valid && bus.ex_wen && (bus.ex_rd == w_rs[i])) begin
                        w_fwd[i]  = 1'b1;
                        w_data[i] = bus.ex_result;
                    end else if (bus.mem_valid && bus.mem_wen && (bus.mem_rd == w_rs[i])) begin
                        w_fwd[i]  = 1'b1;
                        w_data[i] = bus.mem_is_load ? bus.mem_ld_data : bus.mem_alu;
                    end else if (bus.wb_valid && bus.wb_wen && (bus.wb_rd == w_rs[i])) begin
                        w_fwd[i]  = 1'b1;
                        w_data[i] = bus.wb_data;
                    end
                end
                // Load-use depends on the EX match alone, even if MC would win the data mux.
                w_ldu[i] = bus.ex_valid && bus.ex_wen && bus.ex_is_load
                           && (bus.ex_rd == w_rs[i]);
            end
        end
    end

    always_comb begin
        w_waw       = bus.id_wen && r_sb[bus.id_rd];
        w_sb_stall  = bus.id_valid && (w_raw[0] || w_raw[1] || w_waw);
        w_ldu_stall = w_ldu[0] || w_ldu[1];
        w_stall     = w_sb_stall || w_ldu_stall;
    end

    always_comb begin
        bus.stall_id   = rst_n & w_stall;
        bus.op1_fwd    = rst_n & w_fwd[0];
        bus.op2_fwd    = rst_n & w_fwd[1];
        bus.op1_data   = rst_n ? w_data[0] : '0;
        bus.op2_data   = rst_n ? w_data[1] : '0;
        bus.mc_timeout = r_timeout;
    end

    // Clear first, then set, so a same-cycle reissue keeps the entry pending.
    always_comb begin
        w_sb_next = r_sb;
        if (bus.mc_done) begin
            w_sb_next[bus.mc_done_rd] = 1'b0;
        end
        if (bus.mc_issue) begin
            w_sb_next[bus.mc_issue_rd] = 1'b1;
        end
        w_sb_next[0] = 1'b0;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_sb_stall)  w_state_next = MC_WAIT;
            MC_WAIT: if (!w_sb_stall) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        w_cnt_next = '0;
        if (r_state == MC_WAIT) begin
            w_cnt_next = (r_cnt == c_LIMIT) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_sb      <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sb    <= w_sb_next;
            r_cnt   <= w_cnt_next;
            if ((r_state == MC_WAIT) && (w_cnt_next == c_LIMIT)) begin
                r_timeout <= 1'b1;
            end
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] r_perf_ldu;
    logic [31:0] r_perf_mc;
    logic [31:0] r_perf_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_ldu <= '0;
            r_perf_mc  <= '0;
            r_perf_fwd <= '0;
        end else begin
            if (w_ldu_stall && (r_perf_ldu != '1)) r_perf_ldu <= r_perf_ldu + 1'b1;
            if (w_sb_stall && (r_perf_mc != '1))   r_perf_mc  <= r_perf_mc + 1'b1;
            if ((w_fwd != 2'b00) && (r_perf_fwd != '1)) r_perf_fwd <= r_perf_fwd + 1'b1;
        end
    end

    always_comb begin
        bus.perf_ldu_stalls = r_perf_ldu;
        bus.perf_mc_stalls  = r_perf_mc;
        bus.perf_fwd_count  = r_perf_fwd;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_fwd_hazard_ctrl
// Directed self-checking bench for fwd_hazard_ctrl (MC_TIMEOUT = 8).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fwd_hazard_ctrl;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int TMO  = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fwd_hazard_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus ();

    fwd_hazard_ctrl #(
        .XLEN       (XLEN),
        .NUM_REGS   (32),
        .MC_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 0;
        bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_wen = 0;
        bus.ex_valid = 0; bus.ex_wen = 0; bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_result = 0;
        bus.mem_valid = 0; bus.mem_wen = 0; bus.mem_is_load = 0; bus.mem_rd = 0;
        bus.mem_alu = 0; bus.mem_ld_data = 0;
        bus.wb_valid = 0; bus.wb_wen = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.mc_issue = 0; bus.mc_issue_rd = 0; bus.mc_done = 0; bus.mc_done_rd = 0;
        bus.mc_result = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        clr();
        rst_n = 1'b0;
        bus.id_valid = 1; bus.id_rs1 = 5; bus.id_rs1_used = 1;
        bus.ex_valid = 1; bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_rd = 5; bus.ex_result = 32'h55;
        #3;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL rst_stall actual=%b required=0", bus.stall_id); end
        checks++; if (bus.op1_fwd !== 1'b0) begin errors++; $display("FAIL rst_op1_fwd actual=%b required=0", bus.op1_fwd); end
        checks++; if (bus.op1_data !== 32'h0) begin errors++; $display("FAIL rst_op1_data actual=%h required=0", bus.op1_data); end
        checks++; if (bus.mc_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout actual=%b required=0", bus.mc_timeout); end
        tick(); tick();
        rst_n = 1'b1;
        clr();
        tick();
    endtask

    task automatic test_ex_forward();
        clr();
        bus.id_valid = 1; bus.id_rs1 = 5; bus.id_rs1_used = 1;
        bus.ex_valid = 1; bus.ex_wen = 1; bus.ex_rd = 5; bus.ex_result = 32'h1234;
        #1;
        checks++; if (bus.op1_fwd !== 1'b1) begin errors++; $display("FAIL ex_op1_fwd actual=%b required=1", bus.op1_fwd); end
        checks++; if (bus.op1_data !== 32'h1234) begin errors++; $display("FAIL ex_op1_data actual=%h required=1234", bus.op1_data); end
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL ex_stall actual=%b required=0", bus.stall_id); end
        checks++; if (bus.op2_fwd !== 1'b0) begin errors++; $display("FAIL ex_op2_fwd actual=%b required=0", bus.op2_fwd); end
        bus.id_rs1_used = 0;
        #1;
        checks++; if (bus.op1_fwd !== 1'b0) begin errors++; $display("FAIL ex_unused_fwd actual=%b required=0", bus.op1_fwd); end
    endtask

    task automatic test_priority();
        clr();
        bus.id_valid = 1; bus.id_rs2 = 7; bus.id_rs2_used = 1;
        bus.ex_valid = 1; bus.ex_wen = 1; bus.ex_rd = 7; bus.ex_result = 32'hA;
        bus.mem_valid = 1; bus.mem_wen = 1; bus.mem_rd = 7; bus.mem_alu = 32'hB; bus.mem_ld_data = 32'hE;
        bus.wb_valid = 1; bus.wb_wen = 1; bus.wb_rd = 7; bus.wb_data = 32'hC;
        #1;
        checks++; if (bus.op2_data !== 32'hA) begin errors++; $display("FAIL prio_ex actual=%h required=a", bus.op2_data); end
        bus.ex_valid = 0;
        #1;
        checks++; if (bus.op2_data !== 32'hB) begin errors++; $display("FAIL prio_mem actual=%h required=b", bus.op2_data); end
        bus.mem_is_load = 1;
        #1;
        checks++; if (bus.op2_data !== 32'hE) begin errors++; $display("FAIL prio_mem_ld actual=%h required=e", bus.op2_data); end
        bus.mem_valid = 0;
        #1;
        checks++; if (bus.op2_data !== 32'hC) begin errors++; $display("FAIL prio_wb actual=%h required=c", bus.op2_data); end
        bus.wb_wen = 0;
        #1;
        checks++; if ({bus.op2_fwd, bus.op2_data} !== 33'h0) begin errors++; $display("FAIL prio_none actual=%b/%h required=0/0", bus.op2_fwd, bus.op2_data); end
        bus.mc_done = 1; bus.mc_done_rd = 7; bus.mc_result = 32'hF; bus.ex_valid = 1;
        #1;
        checks++; if (bus.op2_data !== 32'hF) begin errors++; $display("FAIL prio_mc actual=%h required=f", bus.op2_data); end
    endtask

    task automatic test_x0();
        clr();
        bus.id_valid = 1; bus.id_rs1_used = 1; bus.id_rs2_used = 1;
        bus.ex_valid = 1; bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_rd = 0; bus.ex_result = 32'h99;
        bus.mc_done = 1; bus.mc_done_rd = 0; bus.mc_result = 32'h98;
        #1;
        checks++; if ({bus.op1_fwd, bus.op2_fwd, bus.stall_id} !== 3'b000) begin errors++; $display("FAIL x0 actual=%b required=000", {bus.op1_fwd, bus.op2_fwd, bus.stall_id}); end
        checks++; if (bus.op1_data !== 32'h0) begin errors++; $display("FAIL x0_data actual=%h required=0", bus.op1_data); end
        clr();
        tick();
    endtask

    task automatic test_load_use();
        clr();
        bus.id_valid = 1; bus.id_rs1 = 3; bus.id_rs1_used = 1;
        bus.ex_valid = 1; bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_rd = 3; bus.ex_result = 32'h40;
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL ldu_stall actual=%b required=1", bus.stall_id); end
        checks++; if (bus.op1_fwd !== 1'b1) begin errors++; $display("FAIL ldu_fwd_while_stalled actual=%b required=1", bus.op1_fwd); end
        tick();
        bus.ex_valid = 0; bus.ex_is_load = 0;
        bus.mem_valid = 1; bus.mem_wen = 1; bus.mem_is_load = 1; bus.mem_rd = 3;
        bus.mem_alu = 32'h5555; bus.mem_ld_data = 32'hDEAD;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL ldu_next_stall actual=%b required=0", bus.stall_id); end
        checks++; if (bus.op1_data !== 32'hDEAD) begin errors++; $display("FAIL ldu_next_data actual=%h required=dead", bus.op1_data); end
        clr();
        tick();
    endtask

    task automatic test_scoreboard();
        clr();
        bus.mc_issue = 1; bus.mc_issue_rd = 9;
        tick();
        bus.mc_issue = 0;
        bus.id_valid = 1; bus.id_rs1 = 9; bus.id_rs1_used = 1;
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL sb_raw_stall actual=%b required=1", bus.stall_id); end
        checks++; if (bus.op1_fwd !== 1'b0) begin errors++; $display("FAIL sb_raw_fwd actual=%b required=0", bus.op1_fwd); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL sb_wait_%0d actual=%b required=1", i, bus.stall_id); end
        end
        bus.mc_done = 1; bus.mc_done_rd = 9; bus.mc_result = 32'h77;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL sb_done_stall actual=%b required=0", bus.stall_id); end
        checks++; if ({bus.op1_fwd, bus.op1_data} !== {1'b1, 32'h77}) begin errors++; $display("FAIL sb_done_data actual=%b/%h required=1/77", bus.op1_fwd, bus.op1_data); end
        tick();
        bus.mc_done = 0;
        #1;
        checks++; if ({bus.stall_id, bus.op1_fwd} !== 2'b00) begin errors++; $display("FAIL sb_cleared actual=%b required=00", {bus.stall_id, bus.op1_fwd}); end
        checks++; if (bus.mc_timeout !== 1'b0) begin errors++; $display("FAIL sb_short_wait_timeout actual=%b required=0", bus.mc_timeout); end
        clr();
        tick();
    endtask

    task automatic test_waw_and_collision();
        clr();
        bus.mc_issue = 1; bus.mc_issue_rd = 9;
        tick();
        bus.mc_issue = 0;
        bus.id_valid = 1; bus.id_wen = 1; bus.id_rd = 9;
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL waw_stall actual=%b required=1", bus.stall_id); end
        bus.mc_issue = 1; bus.mc_issue_rd = 9; bus.mc_done = 1; bus.mc_done_rd = 9;
        tick();
        bus.mc_issue = 0; bus.mc_done = 0;
        bus.id_wen = 0; bus.id_rs1 = 9; bus.id_rs1_used = 1;
        #1;
        checks++; if (bus.stall_id !== 1'b1) begin errors++; $display("FAIL set_clr_same_reg actual=%b required=1", bus.stall_id); end
        bus.mc_done = 1; bus.mc_done_rd = 9; bus.id_valid = 0;
        tick();
        bus.mc_done = 0; bus.id_valid = 1;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL waw_released actual=%b required=0", bus.stall_id); end
        clr();
        bus.mc_issue = 1; bus.mc_issue_rd = 0;
        tick();
        bus.mc_issue = 0;
        bus.id_valid = 1; bus.id_wen = 1; bus.id_rd = 0;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL waw_x0 actual=%b required=0", bus.stall_id); end
        clr();
        tick();
    endtask

    task automatic test_watchdog_and_reset();
        clr();
        bus.mc_issue = 1; bus.mc_issue_rd = 12;
        tick();
        bus.mc_issue = 0;
        bus.id_valid = 1; bus.id_rs1 = 12; bus.id_rs1_used = 1;
        repeat (3) tick();
        checks++; if (bus.mc_timeout !== 1'b0) begin errors++; $display("FAIL wd_early actual=%b required=0", bus.mc_timeout); end
        repeat (TMO + 2) tick();
        checks++; if (bus.mc_timeout !== 1'b1) begin errors++; $display("FAIL wd_set actual=%b required=1", bus.mc_timeout); end
        bus.mc_done = 1; bus.mc_done_rd = 12;
        tick();
        clr();
        tick();
        checks++; if ({bus.mc_timeout, bus.stall_id} !== 2'b10) begin errors++; $display("FAIL wd_sticky actual=%b required=10", {bus.mc_timeout, bus.stall_id}); end
        bus.mc_issue = 1; bus.mc_issue_rd = 12;
        tick();
        bus.mc_issue = 0;
        bus.id_valid = 1; bus.id_rs1 = 12; bus.id_rs1_used = 1;
        bus.id_rs2 = 4; bus.id_rs2_used = 1;
        bus.ex_valid = 1; bus.ex_wen = 1; bus.ex_rd = 4; bus.ex_result = 32'hABC;
        tick(); tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.stall_id, bus.op2_fwd, bus.mc_timeout} !== 3'b000) begin errors++; $display("FAIL rst_mid_wait actual=%b required=000", {bus.stall_id, bus.op2_fwd, bus.mc_timeout}); end
        checks++; if (bus.op2_data !== 32'h0) begin errors++; $display("FAIL rst_mid_wait_data actual=%h required=0", bus.op2_data); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.stall_id !== 1'b0) begin errors++; $display("FAIL rst_sb_cleared actual=%b required=0", bus.stall_id); end
        checks++; if (bus.op2_data !== 32'hABC) begin errors++; $display("FAIL rst_release_fwd actual=%h required=abc", bus.op2_data); end
        clr();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        test_reset();
        test_ex_forward();
        test_priority();
        test_x0();
        test_load_use();
        test_scoreboard();
        test_waw_and_collision();
        test_watchdog_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised operand-forwarding and hazard controller for the in-order pipeline.
- Takes the decode-stage (ID) source registers, plus EX/MEM/WB destination info and results, and returns per-operand bypass data.
- Adds three things the earlier forwarding logic lacked: load-use stall generation, a register scoreboard for the variable-latency multi-cycle unit (MC: mul/div), and a stall-timeout watchdog.
- Sits between decode and the execute-stage operand muxes.

Parameters:
XLEN, 32, datapath width in bits
NUM_REGS, 32, architectural register count; AW = $clog2(NUM_REGS)
MC_TIMEOUT, 64, maximum consecutive MC_WAIT cycles before the error flag sets

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_rs1 / id_rs2  in  AW  ID source registers
id_rs1_used / id_rs2_used  in  1  the instruction reads that source
id_rd  in  AW  ID destination register
id_wen  in  1  ID instruction writes rd
ex_valid, ex_wen, ex_is_load  in  1 each  EX stage status
ex_rd  in  AW  EX destination
ex_result  in  XLEN  EX ALU result
mem_valid, mem_wen, mem_is_load  in  1 each  MEM stage status
mem_rd  in  AW  MEM destination
mem_alu  in  XLEN  MEM ALU result
mem_ld_data  in  XLEN  MEM load data
wb_valid, wb_wen  in  1 each  WB status
wb_rd  in  AW  WB destination
wb_data  in  XLEN  WB write data
mc_issue  in  1  MC op accepted this cycle
mc_issue_rd  in  AW  destination of the issued MC op
mc_done  in  1  MC result valid this cycle
mc_done_rd  in  AW  destination of the completing MC op
mc_result  in  XLEN  MC result
op1_fwd / op2_fwd  out  1  use the bypass data instead of the register file
op1_data / op2_data  out  XLEN  bypass data
stall_id  out  1  hold IF/ID and inject a bubble into EX
mc_timeout  out  1  sticky watchdog error

Behaviour:
- Source matching
  - A source "hits" a stage when the source is used, the stage is valid with wen=1, the stage rd equals the source, and the source is not x0.
  - x0 never matches, never stalls, and never forwards.
- Forwarding priority per operand: MC completion (mc_done and mc_done_rd match) > EX > MEM > WB.
  - EX hit: data = ex_result.
  - MEM hit: data = mem_ld_data if mem_is_load, else mem_alu.
  - WB hit: data = wb_data.
  - No hit: opN_fwd=0 and opN_data=0.
- Load-use hazard
  - An EX hit with ex_is_load=1 asserts stall_id for exactly that cycle, combinationally.
  - The following cycle the load is in MEM and is forwarded from mem_ld_data.
  - While stalled, opN_fwd is still driven; the consumer ignores it.
- Scoreboard: NUM_REGS-bit register sb, with sb[0] hardwired to 0.
  - mc_issue sets sb[mc_issue_rd] at the next edge.
  - mc_done clears sb[mc_done_rd].
  - Simultaneous set and clear of the same register: the set wins, because the newer issue is pending.
  - Clearing a register that is not set is a no-op.
- Scoreboard stall: stall_id asserts when id_valid=1 and any of the following holds:
  - a used source has its sb bit set and is not being bypassed from mc_done this cycle (RAW);
  - id_wen=1 and sb[id_rd]=1 (WAW).
- State machine: RUN / MC_WAIT.
  - RUN -> MC_WAIT when a scoreboard stall occurs.
  - MC_WAIT -> RUN in the first cycle with no scoreboard stall.
  - A wait counter runs in MC_WAIT (saturating, reset on entry).
  - The counter reaching MC_TIMEOUT sets mc_timeout. mc_timeout clears only on reset.
- Output registration: stall_id and all forward outputs are combinational from inputs and state. Latency is 0 cycles.
- Reset (asynchronous, active-low)
  - sb=0, state=RUN, counter=0, mc_timeout=0.
  - stall_id, opN_fwd and opN_data are forced to 0 while rst_n=0.
  - A reset asserted mid-MC_WAIT abandons all pending scoreboard entries.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined, the block adds these outputs:
  - perf_ldu_stalls (32-bit): counts load-use stall cycles.
  - perf_mc_stalls (32-bit): counts scoreboard stall cycles.
  - perf_fwd_count (32-bit): counts cycles where op1_fwd or op2_fwd is asserted.
- All three counters are saturating, reset to 0, and count only while rst_n=1.
- When undefined, these ports and the counters are absent and there is no functional difference.

Test Plan:
- EX forward: ex rd=5, ex_result=0x1234, ID rs1=5 used -> op1_fwd=1, op1_data=0x1234, stall_id=0.
- Priority: EX rd=7=0xA, MEM rd=7 alu=0xB, WB rd=7=0xC, ID rs2=7 -> op2_data=0xA. With EX invalid -> 0xB. With MEM also invalid -> 0xC.
- Load-use: EX load rd=3, ID rs1=3 -> stall_id=1 for 1 cycle. Next cycle MEM load with mem_ld_data=0xDEAD -> op1_data=0xDEAD, stall_id=0.
- Scoreboard: mc_issue rd=9, then ID rs1=9 -> stall_id=1 and state MC_WAIT for 4 cycles. Then mc_done rd=9, mc_result=0x77 -> stall_id=0, op1_data=0x77, state RUN next cycle.
- Edge cases:
  - x0 sources never forward or stall.
  - WAW: ID id_rd=9, id_wen=1 with sb[9]=1 -> stall.
  - mc_issue and mc_done on the same register in one cycle -> sb bit remains 1.
- Watchdog and reset: MC_TIMEOUT=8, hold a scoreboard stall for 8 cycles -> mc_timeout=1 and stays 1. Assert rst_n=0 mid-wait -> all outputs 0, sb=0, and the next ID source is not stalled.
